// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle shift-add multiplier that borrows the shared ALU.
// Produces the low 32 bits of op_a*op_b by alternating ALU add and
// shift-left passes, one multiplier bit per ADD/SHL pair.
module alu_mul_seq #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] alu_srca,
    output logic [31:0] alu_srcb,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_result
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 5;
    localparam int unsigned OPW = 3;

    localparam logic [OPW-1:0] ALU_ADD = 3'b000;
    localparam logic [OPW-1:0] ALU_SLL = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_SHL  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [DW-1:0]  acc_q, acc_d;
    logic [DW-1:0]  mcand_q, mcand_d;
    logic [DW-1:0]  mplier_q, mplier_d;
    logic [DW-1:0]  result_q, result_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  mplier_shr;

    assign mplier_shr = mplier_q >> 1;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state, datapath updates and ALU drive decoded from current state.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        alu_srca = '0;
        alu_srcb = '0;
        alu_ctrl = ALU_ADD;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    cnt_d    = '0;
                    state_d  = S_ADD;
                end
            end
            S_ADD: begin
                alu_srca = acc_q;
                alu_srcb = mcand_q;
                alu_ctrl = ALU_ADD;
                if (mplier_q[0]) begin
                    acc_d = alu_result;
                end
                state_d = S_SHL;
            end
            S_SHL: begin
                alu_srca = mcand_q;
                alu_srcb = DW'(1);
                alu_ctrl = ALU_SLL;
                mcand_d  = alu_result;
                mplier_d = mplier_shr;
                cnt_d    = cnt_q + CW'(1);
                // acc is final here, so latch it on the way into DONE.
                if ((cnt_q == CW'(DW - 1)) || (EARLY_EXIT && (mplier_shr == '0))) begin
                    result_d = acc_q;
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_ADD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status decoded straight from the state register.
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed checks of the shift-add multiplier, including
// cycle-exact latency, ALU drive per cycle, ignored starts and abort by reset.
module tb_alu_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start_e, start_n;
    logic [31:0] op_a, op_b;

    logic        busy_e, done_e, busy_n, done_n;
    logic [31:0] result_e, srca_e, srcb_e, alu_res_e;
    logic [31:0] result_n, srca_n, srcb_n, alu_res_n;
    logic [2:0]  ctrl_e, ctrl_n;

    int tests_run;
    int tests_failed;

    // Observed signals of whichever instance the current test targets.
    bit          sel;
    logic        o_busy, o_done;
    logic [31:0] o_result, o_srca, o_srcb;
    logic [2:0]  o_ctrl;

    alu_mul_seq #(.EARLY_EXIT(1'b1)) dut_e (
        .clk(clk), .rst_n(rst_n), .start(start_e), .op_a(op_a), .op_b(op_b),
        .busy(busy_e), .done(done_e), .result(result_e),
        .alu_srca(srca_e), .alu_srcb(srcb_e), .alu_ctrl(ctrl_e),
        .alu_result(alu_res_e)
    );

    alu_mul_seq #(.EARLY_EXIT(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .start(start_n), .op_a(op_a), .op_b(op_b),
        .busy(busy_n), .done(done_n), .result(result_n),
        .alu_srca(srca_n), .alu_srcb(srcb_n), .alu_ctrl(ctrl_n),
        .alu_result(alu_res_n)
    );

    // Behavioural model of the shared ALU for the two operations used.
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] c);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a << b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    always_comb alu_res_e = alu_model(srca_e, srcb_e, ctrl_e);
    always_comb alu_res_n = alu_model(srca_n, srcb_n, ctrl_n);

    always_comb begin
        o_busy   = sel ? busy_n   : busy_e;
        o_done   = sel ? done_n   : done_e;
        o_result = sel ? result_n : result_e;
        o_srca   = sel ? srca_n   : srca_e;
        o_srcb   = sel ? srcb_n   : srcb_e;
        o_ctrl   = sel ? ctrl_n   : ctrl_e;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_drive(input string tag);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_srca"}, o_srca, 32'h0);
        check({tag, "_srcb"}, o_srcb, 32'h0);
        check({tag, "_ctrl"}, 32'(o_ctrl), 32'd0);
    endtask

    // Runs one multiply starting from an IDLE cycle; n is the hand-derived
    // iteration count. inj_cyc pulses a competing start, abort_cyc resets.
    task automatic run_op(input string tag, input bit s, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [31:0] exp_res,
                          input int inj_cyc, input bit done_start, input int abort_cyc);
        logic [31:0] mask;
        int k;
        sel = s;
        check_idle_drive({tag, "_c0"});
        op_a = a;
        op_b = b;
        if (s) start_n = 1'b1; else start_e = 1'b1;
        for (int t = 1; t <= 2 * n + 1; t++) begin
            step();
            start_e = 1'b0;
            start_n = 1'b0;
            if (t <= 2 * n) begin
                check({tag, "_busy"}, 32'(o_busy), 32'd1);
                check({tag, "_done_early"}, 32'(o_done), 32'd0);
                if (t % 2 == 1) begin
                    k = (t - 1) / 2;
                    mask = (32'd1 << k) - 32'd1;
                    check({tag, "_add_ctrl"}, 32'(o_ctrl), 32'd0);
                    check({tag, "_add_srca"}, o_srca, a * (b & mask));
                    check({tag, "_add_srcb"}, o_srcb, a << k);
                end else begin
                    k = (t - 2) / 2;
                    check({tag, "_shl_ctrl"}, 32'(o_ctrl), 32'd1);
                    check({tag, "_shl_srca"}, o_srca, a << k);
                    check({tag, "_shl_srcb"}, o_srcb, 32'd1);
                end
            end else begin
                check({tag, "_done_busy"}, 32'(o_busy), 32'd1);
                check({tag, "_done"}, 32'(o_done), 32'd1);
                check({tag, "_result"}, o_result, exp_res);
                check({tag, "_done_srca"}, o_srca, 32'h0);
                check({tag, "_done_ctrl"}, 32'(o_ctrl), 32'd0);
                if (done_start) begin
                    op_a = 32'hDEAD_BEEF;
                    op_b = 32'h3;
                    if (s) start_n = 1'b1; else start_e = 1'b1;
                end
            end
            if (t == inj_cyc) begin
                op_a = 32'd2;
                op_b = 32'd2;
                if (s) start_n = 1'b1; else start_e = 1'b1;
            end
            if (t == abort_cyc) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                check({tag, "_abort_busy"}, 32'(o_busy), 32'd0);
                check({tag, "_abort_done"}, 32'(o_done), 32'd0);
                check({tag, "_abort_result"}, o_result, 32'h0);
                return;
            end
        end
        step();
        start_e = 1'b0;
        start_n = 1'b0;
        check_idle_drive({tag, "_post"});
        check({tag, "_hold"}, o_result, exp_res);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        sel     = 1'b0;
        rst_n   = 1'b0;
        start_e = 1'b0;
        start_n = 1'b0;
        op_a    = 32'h0;
        op_b    = 32'h0;
        step();
        step();
        check_idle_drive("reset_e");
        check("reset_result_e", result_e, 32'h0);
        check("reset_result_n", result_n, 32'h0);
        check("reset_busy_n", 32'(busy_n), 32'd0);
        rst_n = 1'b1;
        step();

        // 3*5: N=3, done in cycle 7; a start during DONE must be ignored.
        run_op("mul3x5", 1'b0, 32'd3, 32'd5, 3, 32'h0000_000F, 0, 1'b1, 0);
        // Back-to-back all-ones: N=32, done in cycle 65.
        run_op("mul_ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'h0000_0001, 0, 1'b0, 0);
        // Zero multiplier exits after one iteration, done in cycle 3.
        run_op("mul_b0", 1'b0, 32'h1234_5678, 32'h0, 1, 32'h0, 0, 1'b0, 0);
        // 2^16 * 2^16 wraps to zero: N=17, done in cycle 35.
        run_op("mul_wrap", 1'b0, 32'h0001_0000, 32'h0001_0000, 17, 32'h0, 0, 1'b0, 0);
        // 7*9 with a competing start at cycle 4: N=4, result 0x3F.
        run_op("mul7x9", 1'b0, 32'd7, 32'd9, 4, 32'h0000_003F, 4, 1'b0, 0);
        // 0x1234*0x5678 aborted by reset at cycle 5 (N would be 15).
        run_op("abort", 1'b0, 32'h0000_1234, 32'h0000_5678, 15, 32'h0, 0, 1'b0, 5);
        // Fresh operation after the abort.
        run_op("mul6x7", 1'b0, 32'd6, 32'd7, 3, 32'h0000_002A, 0, 1'b0, 0);
        // No early exit: op_b=1 still takes 32 iterations, result = op_a.
        run_op("ee0_b1", 1'b1, 32'hFFFF_FFFF, 32'd1, 32, 32'hFFFF_FFFF, 0, 1'b0, 0);
        run_op("ee0_3x5", 1'b1, 32'd3, 32'd5, 32, 32'h0000_000F, 0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle shift-add multiplier controller for the shared 32-bit ALU.
- Produces the low 32 bits of op_a*op_b (RV32M MUL semantics, signed/unsigned identical).
- Drives the ALU operand and control inputs, issuing add (000) and shift-left-logical (001), and consumes ALUResult each cycle.
- Sits beside the execute stage. The core mux hands the ALU to this block while busy=1.

Parameters:
- EARLY_EXIT, 1: 1 = stop when the remaining multiplier bits are all zero; 0 = always run 32 iterations.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op_a  input  32  multiplicand
- op_b  input  32  multiplier
- busy  output  1  high in ADD, SHL, DONE
- done  output  1  one-cycle pulse, result valid
- result  output  32  product, low 32 bits
- alu_srca  output  32  to ALU SrcA
- alu_srcb  output  32  to ALU SrcB
- alu_ctrl  output  3  to ALU ALUControl
- alu_result  input  32  from ALU ALUResult

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- rst_n=0 at a clk edge: state=IDLE, busy=0, done=0, result=0, all internal registers (acc, mcand, mplier, cnt[4:0]) = 0.
- Reset mid-operation aborts the operation: no done pulse, result=0.
- ALU drive is combinational from state:
  - IDLE/DONE: srca=0, srcb=0, ctrl=000.
  - ADD: srca=acc, srcb=mcand, ctrl=000.
  - SHL: srca=mcand, srcb=1, ctrl=001.
- IDLE:
  - start=1 → acc<=0, mcand<=op_a, mplier<=op_b, cnt<=0, next=ADD.
  - start=0 → stay.
- ADD: if mplier[0]=1 then acc<=alu_result (wraps mod 2^32), else acc holds; next=SHL.
- SHL:
  - Updates: mcand<=alu_result; mplier<=mplier>>1 (logical); cnt<=cnt+1.
  - Next = DONE if cnt==31, or if EARLY_EXIT=1 and (mplier>>1)==0.
  - Otherwise next = ADD.
- DONE: done=1 for exactly one cycle; result<=acc registered on entry to DONE, so result is valid in the done cycle; next=IDLE.
- result holds its value until the next DONE or reset.
- start while busy=1 is ignored and not queued. start in the DONE cycle is ignored.
- Back-to-back operation: start may be accepted in the IDLE cycle immediately following DONE.
- Iteration count N:
  - EARLY_EXIT=1: N = max(1, index of highest set bit of op_b + 1).
  - EARLY_EXIT=0: N = 32.
- Latency: start sampled in cycle 0 → ADD/SHL occupy cycles 1..2N → done=1 in cycle 2N+1.
- op_a and op_b are sampled only at the accepting edge; later changes have no effect.
- No internal overflow detection; mcand shifts out silently.

Test Plan:
- Reset, then op_a=3, op_b=5, start=1 for one cycle → busy=1 from cycle 1; done=1 exactly in cycle 7 (N=3); result=0x0000000F.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF → done in cycle 65; result=0x00000001. With EARLY_EXIT=0, op_b=1 → done in cycle 65 and result=op_a.
- op_a=0x12345678, op_b=0 → done in cycle 3, result=0. Also op_a=0x00010000, op_b=0x00010000 → result=0x00000000 (wrap), done in cycle 35.
- During an operation 7*9, pulse start with op_a=2, op_b=2 at cycle 4 → ignored; result=0x0000003F; exactly one done pulse.
- Assert rst_n=0 at cycle 5 of 0x1234*0x5678 → next cycle busy=0, done=0, result=0. Then a new start of 6*7 → result=0x2A.
- Every ADD cycle: check alu_ctrl=000, alu_srca=acc, alu_srcb=mcand. Every SHL cycle: check alu_ctrl=001, alu_srcb=1. In IDLE: all ALU drive outputs = 0.
